counter_output_checker: RTL and testbench

Synthesizable output-vector checker that sits directly downstream of the counter formal-verification pair: it consumes the 8 fabric outputs (out_q_counter_*__gfpga) and the 8 benchmark outputs (out_q_counter_*__bench) each cycle and produces per-bit mismatch flags, a saturating error count, and a pass/fail verdict. It replaces the testbench-only flag/nb_error logic, so the same comparison runs on silicon bring-up boards and in emulation.

---
 rtl/counter_output_checker.sv | 180 ++++++++++++++++++
 tb/tb_counter_output_checker.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_output_checker.sv
// counter_output_checker
// Compares the fabric outputs of the counter against the benchmark outputs
// once per clock while a check run is active. It reports per-bit mismatch
// flags, a saturating count of mismatch rising edges and a pass/fail verdict.
// A run is: start -> SKIP_CYCLES ignored samples -> RUN_CYCLES checked
// samples -> DONE, where the results hold until the next start or reset.
//
// Optional feature macro: COUNTER_CHECKER_FIRST_ERR_EN
//   defined   : first_err_cycle / first_err_bits record the first failing
//               check sample and its mismatching bits.
//   undefined : no capture registers; both outputs are tied to zero.

module counter_output_checker #(
  parameter int WIDTH       = 8,
  parameter int ERR_W       = 16,
  parameter int SKIP_CYCLES = 1,
  parameter int RUN_CYCLES  = 10
) (
  input  logic             clk_counter,
  input  logic             rst_n_counter,
  input  logic             start,
  input  logic [WIDTH-1:0] out_gfpga,
  input  logic [WIDTH-1:0] out_bench,
  input  logic [WIDTH-1:0] bench_dc,
  output logic [WIDTH-1:0] mismatch_flag,
  output logic [ERR_W-1:0] nb_error,
  output logic [15:0]      first_err_cycle,
  output logic [WIDTH-1:0] first_err_bits,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  // Enough headroom to add a full-width popcount to the counter before the
  // clamp is applied, whichever of the two is wider.
  localparam int POP_W = $clog2(WIDTH + 1);
  localparam int SUM_W = ((ERR_W > POP_W) ? ERR_W : POP_W) + 1;

  localparam logic [ERR_W-1:0] ERR_MAX   = '1;
  localparam logic [31:0]      SKIP_LAST = 32'(SKIP_CYCLES - 1);
  localparam logic [31:0]      RUN_LAST  = 32'(RUN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t           state;
  logic [31:0]      cnt;
  logic [WIDTH-1:0] cmp;
  logic [WIDTH-1:0] rise;
  logic [SUM_W-1:0] rise_sum;
  logic [SUM_W-1:0] err_sum;
  logic [ERR_W-1:0] nb_next;

  // Masked comparison of the current sample and the saturated error count it would produce.
  always_comb begin
    cmp      = (out_gfpga ^ out_bench) & ~bench_dc;
    rise     = cmp & ~mismatch_flag;
    rise_sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rise_sum = rise_sum + SUM_W'(rise[i]);
    end
    err_sum = SUM_W'(nb_error) + rise_sum;
    if (err_sum > SUM_W'(ERR_MAX)) begin
      nb_next = ERR_MAX;
    end else begin
      nb_next = err_sum[ERR_W-1:0];
    end
  end

  // Run sequencer: phase counting, comparison results and registered status flags.
  always_ff @(posedge clk_counter or negedge rst_n_counter) begin
    if (!rst_n_counter) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      mismatch_flag <= '0;
      nb_error      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            cnt           <= '0;
            mismatch_flag <= '0;
            nb_error      <= '0;
            if (SKIP_CYCLES > 0) begin
              state <= ST_SKIP;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end else if (RUN_CYCLES > 0) begin
              state <= ST_CHECK;
              busy  <= 1'b1;
              done  <= 1'b0;
              pass  <= 1'b0;
            end else begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end
          end
        end

        ST_SKIP: begin
          if (cnt == SKIP_LAST) begin
            cnt <= '0;
            if (RUN_CYCLES > 0) begin
              state <= ST_CHECK;
            end else begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= 1'b1;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        ST_CHECK: begin
          mismatch_flag <= cmp;
          nb_error      <= nb_next;
          if (cnt == RUN_LAST) begin
            cnt   <= '0;
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (nb_next == '0);
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

`ifdef COUNTER_CHECKER_FIRST_ERR_EN
  logic        first_err_seen;
  logic [15:0] sample_idx;

  // The check-sample index is reported on 16 bits and sticks at 0xFFFF on long runs.
  assign sample_idx = (cnt > 32'h0000_FFFF) ? 16'hFFFF : cnt[15:0];

  // Latch the index and bits of the first failing check sample; later failures leave it alone.
  always_ff @(posedge clk_counter or negedge rst_n_counter) begin
    if (!rst_n_counter) begin
      first_err_seen  <= 1'b0;
      first_err_cycle <= '0;
      first_err_bits  <= '0;
    end else begin
      if ((state == ST_IDLE || state == ST_DONE) && start) begin
        first_err_seen  <= 1'b0;
        first_err_cycle <= '0;
        first_err_bits  <= '0;
      end else if (state == ST_CHECK && !first_err_seen && cmp != '0) begin
        first_err_seen  <= 1'b1;
        first_err_cycle <= sample_idx;
        first_err_bits  <= cmp;
      end
    end
  end
`else
  assign first_err_cycle = '0;
  assign first_err_bits  = '0;
`endif

endmodule

// File: tb/tb_counter_output_checker.sv
// tb_counter_output_checker
// Drives directed and randomized check runs into counter_output_checker and
// scores every sample and every verdict against a reference model built from
// the comparison rules. A second instance with a 3-bit error counter covers
// counter saturation. Honours COUNTER_CHECKER_FIRST_ERR_EN like the design.

module tb_counter_output_checker;

  localparam int WIDTH     = 8;
  localparam int ERR_W     = 16;
  localparam int SKIP_N    = 1;
  localparam int RUN_N     = 10;
  localparam int RUN_LEN   = SKIP_N + RUN_N;
  localparam int SAT_ERR_W = 3;
  localparam int SAT_RUN_N = 20;
  localparam int SAT_LEN   = SKIP_N + SAT_RUN_N;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             start     = 1'b0;
  logic             start_sat = 1'b0;
  logic [WIDTH-1:0] out_gfpga = '0;
  logic [WIDTH-1:0] out_bench = '0;
  logic [WIDTH-1:0] bench_dc  = '0;

  logic [WIDTH-1:0]     mismatch_flag;
  logic [ERR_W-1:0]     nb_error;
  logic [15:0]          first_err_cycle;
  logic [WIDTH-1:0]     first_err_bits;
  logic                 busy, done, pass;

  logic [WIDTH-1:0]     sat_mismatch_flag;
  logic [SAT_ERR_W-1:0] sat_nb_error;
  logic [15:0]          sat_first_err_cycle;
  logic [WIDTH-1:0]     sat_first_err_bits;
  logic                 sat_busy, sat_done, sat_pass;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0] flag;
    logic [15:0]      nb;
  } sample_exp_t;

  typedef struct {
    logic [15:0]      nb;
    logic             pass;
    logic [15:0]      fc;
    logic [WIDTH-1:0] fb;
  } run_exp_t;

  sample_exp_t sample_q[$];
  run_exp_t    run_q[$];

  logic [WIDTH-1:0] g_arr [0:RUN_LEN-1];
  logic [WIDTH-1:0] b_arr [0:RUN_LEN-1];
  logic [WIDTH-1:0] dc_arr[0:RUN_LEN-1];

  counter_output_checker #(
    .WIDTH(WIDTH), .ERR_W(ERR_W), .SKIP_CYCLES(SKIP_N), .RUN_CYCLES(RUN_N)
  ) dut (
    .clk_counter    (clk),
    .rst_n_counter  (rst_n),
    .start          (start),
    .out_gfpga      (out_gfpga),
    .out_bench      (out_bench),
    .bench_dc       (bench_dc),
    .mismatch_flag  (mismatch_flag),
    .nb_error       (nb_error),
    .first_err_cycle(first_err_cycle),
    .first_err_bits (first_err_bits),
    .busy           (busy),
    .done           (done),
    .pass           (pass)
  );

  counter_output_checker #(
    .WIDTH(WIDTH), .ERR_W(SAT_ERR_W), .SKIP_CYCLES(SKIP_N), .RUN_CYCLES(SAT_RUN_N)
  ) dut_sat (
    .clk_counter    (clk),
    .rst_n_counter  (rst_n),
    .start          (start_sat),
    .out_gfpga      (out_gfpga),
    .out_bench      (out_bench),
    .bench_dc       (bench_dc),
    .mismatch_flag  (sat_mismatch_flag),
    .nb_error       (sat_nb_error),
    .first_err_cycle(sat_first_err_cycle),
    .first_err_bits (sat_first_err_bits),
    .busy           (sat_busy),
    .done           (sat_done),
    .pass           (sat_pass)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fillClean();
    for (int s = 0; s < RUN_LEN; s++) begin
      g_arr[s]  = WIDTH'(s);
      b_arr[s]  = WIDTH'(s);
      dc_arr[s] = '0;
    end
  endtask

  task automatic fillRandom();
    for (int s = 0; s < RUN_LEN; s++) begin
      b_arr[s]  = WIDTH'($urandom);
      g_arr[s]  = ($urandom_range(0, 2) == 0) ? (b_arr[s] ^ WIDTH'($urandom)) : b_arr[s];
      dc_arr[s] = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : '0;
    end
  endtask

  // One run: model the expected outcome, queue it, then drive the samples.
  // busy_start_at >= 0 pulses start again on that sample; reset_after >= 0
  // resets the DUT once that many samples have been taken.
  task automatic applyStimulus(input int busy_start_at, input int reset_after);
    logic [WIDTH-1:0] prev_cmp, cmp;
    int               nb, n_samples;
    bit               found;
    sample_exp_t      se;
    run_exp_t         re;
    prev_cmp  = '0;
    nb        = 0;
    found     = 0;
    re.fc     = '0;
    re.fb     = '0;
    n_samples = (reset_after >= 0) ? reset_after : RUN_LEN;
    for (int s = 0; s < RUN_LEN; s++) begin
      if (s < SKIP_N) begin
        se.flag = '0;
        se.nb   = '0;
      end else begin
        cmp = (g_arr[s] ^ b_arr[s]) & ~dc_arr[s];
        nb  = nb + $countones(cmp & ~prev_cmp);
        if (nb > 65535) nb = 65535;
        prev_cmp = cmp;
        if (!found && cmp != '0) begin
          found = 1;
          re.fc = 16'(s - SKIP_N);
          re.fb = cmp;
        end
        se.flag = cmp;
        se.nb   = 16'(nb);
      end
      if (s < n_samples) sample_q.push_back(se);
    end
    re.nb   = 16'(nb);
    re.pass = (nb == 0);
`ifndef COUNTER_CHECKER_FIRST_ERR_EN
    re.fc = '0;
    re.fb = '0;
`endif
    if (reset_after < 0) run_q.push_back(re);

    @(negedge clk);
    start     = 1'b1;
    out_gfpga = WIDTH'($urandom);
    out_bench = WIDTH'($urandom);
    bench_dc  = '0;
    for (int s = 0; s < n_samples; s++) begin
      @(negedge clk);
      start     = (s == busy_start_at);
      out_gfpga = g_arr[s];
      out_bench = b_arr[s];
      bench_dc  = dc_arr[s];
    end
    @(negedge clk);
    start     = 1'b0;
    out_gfpga = WIDTH'($urandom);
    out_bench = WIDTH'($urandom);
    if (reset_after < 0) begin
      checkOutput("done_on_time", 32'(done), 32'd1);
      checkOutput("busy_after_run", 32'(busy), 32'd0);
    end else begin
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_busy", 32'(busy), 32'd0);
      checkOutput("rst_mid_done", 32'(done), 32'd0);
      checkOutput("rst_mid_nb_error", 32'(nb_error), 32'd0);
      checkOutput("rst_mid_mismatch_flag", 32'(mismatch_flag), 32'd0);
      checkOutput("rst_mid_pass", 32'(pass), 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
    end
  endtask

  // Monitor: score each sample's outputs one cycle after the DUT took it, and the verdict when done rises.
  initial begin
    logic        busy_d, done_d;
    sample_exp_t se;
    run_exp_t    re;
    busy_d = 1'b0;
    done_d = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end else begin
        if (busy_d) begin
          if (sample_q.size() == 0) begin
            checkOutput("unexpected_sample", 32'd1, 32'd0);
          end else begin
            se = sample_q.pop_front();
            checkOutput("mismatch_flag", 32'(mismatch_flag), 32'(se.flag));
            checkOutput("nb_error", 32'(nb_error), 32'(se.nb));
          end
        end
        if (done && !done_d) begin
          if (run_q.size() == 0) begin
            checkOutput("unexpected_verdict", 32'd1, 32'd0);
          end else begin
            re = run_q.pop_front();
            checkOutput("verdict_nb_error", 32'(nb_error), 32'(re.nb));
            checkOutput("verdict_pass", 32'(pass), 32'(re.pass));
            checkOutput("first_err_cycle", 32'(first_err_cycle), 32'(re.fc));
            checkOutput("first_err_bits", 32'(first_err_bits), 32'(re.fb));
          end
        end
        busy_d = busy;
        done_d = done;
      end
    end
  end

  // Main sequence: reset state, directed runs, randomized runs, saturation run.
  initial begin
    int sat_nb;
    int sat_exp_nb;
    logic [WIDTH-1:0] sat_prev, sat_cmp;

    #12;
    checkOutput("reset_mismatch_flag", 32'(mismatch_flag), 32'd0);
    checkOutput("reset_nb_error", 32'(nb_error), 32'd0);
    checkOutput("reset_first_err_cycle", 32'(first_err_cycle), 32'd0);
    checkOutput("reset_first_err_bits", 32'(first_err_bits), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_pass", 32'(pass), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    $display("[TB] clean incrementing run");
    fillClean();
    applyStimulus(-1, -1);

    $display("[TB] bit 3 inverted on check samples 2..4");
    fillClean();
    for (int c = 2; c <= 4; c++) g_arr[SKIP_N + c] = g_arr[SKIP_N + c] ^ 8'h08;
    applyStimulus(-1, -1);

    $display("[TB] all bits mismatch on check sample 0");
    fillClean();
    g_arr[SKIP_N] = 8'h00;
    b_arr[SKIP_N] = 8'hFF;
    applyStimulus(-1, -1);

    $display("[TB] same with upper nibble don't-care");
    dc_arr[SKIP_N] = 8'hF0;
    applyStimulus(-1, -1);

    $display("[TB] mismatch in skip window only, extra start while busy");
    fillClean();
    g_arr[0] = b_arr[0] ^ 8'hFF;
    applyStimulus(5, -1);

    $display("[TB] reset in the middle of the check window");
    fillClean();
    for (int c = 0; c <= 4; c++) g_arr[SKIP_N + c] = g_arr[SKIP_N + c] ^ 8'h81;
    applyStimulus(-1, SKIP_N + 5);

    $display("[TB] clean run after reset");
    fillClean();
    applyStimulus(-1, -1);

    $display("[TB] randomized runs");
    for (int r = 0; r < 16; r++) begin
      fillRandom();
      applyStimulus(($urandom_range(0, 1) == 1) ? int'($urandom_range(SKIP_N + 1, RUN_LEN - 1)) : -1, -1);
    end

    $display("[TB] saturation with a 3-bit error counter");
    sat_nb     = 0;
    sat_exp_nb = 0;
    sat_prev   = '0;
    @(negedge clk);
    start_sat = 1'b1;
    for (int s = 0; s < SAT_LEN; s++) begin
      @(negedge clk);
      if (s > 0) checkOutput("sat_nb_error", 32'(sat_nb_error), 32'(sat_exp_nb));
      start_sat = 1'b0;
      out_bench = WIDTH'(s);
      out_gfpga = WIDTH'(s) ^ (((s >= SKIP_N) && ((s - SKIP_N) % 2 == 0)) ? 8'h01 : 8'h00);
      bench_dc  = '0;
      if (s >= SKIP_N) begin
        sat_cmp = (out_gfpga ^ out_bench) & ~bench_dc;
        sat_nb  = sat_nb + $countones(sat_cmp & ~sat_prev);
        if (sat_nb > 7) sat_nb = 7;
        sat_prev = sat_cmp;
      end
      sat_exp_nb = sat_nb;
    end
    @(negedge clk);
    checkOutput("sat_nb_error_final", 32'(sat_nb_error), 32'd7);
    checkOutput("sat_done", 32'(sat_done), 32'd1);
    checkOutput("sat_pass", 32'(sat_pass), 32'd0);

    repeat (3) @(negedge clk);
    checkOutput("leftover_samples", 32'(sample_q.size()), 32'd0);
    checkOutput("leftover_verdicts", 32'(run_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] timeout");
  end

endmodule
